// File: rtl/second_fft_sched.sv
// Second-stage FFT input sequencer: walks every channel of a buffered block, reads
// FFT_LEN samples per channel and streams them out under a frame-credit limit.
module second_fft_sched #(
    parameter int DATA_WIDTH   = 64,
    parameter int N_FREQ       = 128,
    parameter int DEPTH        = 32,
    parameter int ASSERT       = 2,
    parameter int MAX_INFLIGHT = 4,
    parameter int IW           = $clog2(N_FREQ),
    parameter int CW           = $clog2(DEPTH) - $clog2(ASSERT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun,
    output logic                  credit_err,
    output logic [15:0]           frame_cnt,
    output logic                  rd_en,
    output logic [IW+CW-1:0]      rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [CW-1:0]         data_count,
    output logic [IW-1:0]         data_index,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic                  fft_done
);
    localparam int FFT_LEN = DEPTH / ASSERT;
    localparam int KW      = $clog2(MAX_INFLIGHT + 1);
    localparam logic [KW-1:0] CRED_MAX = KW'(MAX_INFLIGHT);
    localparam logic [CW-1:0] SMP_LAST = CW'(FFT_LEN - 1);
    localparam logic [IW-1:0] CH_LAST  = IW'(N_FREQ - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

    state_t                 state_r, state_nxt_s;
    logic [IW-1:0]          ch_r;
    logic [CW-1:0]          smp_r;
    logic [KW-1:0]          credits_r;
    logic                   pend_r;
    logic [IW+CW-1:0]       tag_r;
    logic [1:0]             occ_r;
    logic [DATA_WIDTH-1:0]  data0_r, data1_r;
    logic [IW+CW-1:0]       tag0_r, tag1_r;
    logic                   busy_r, done_r, overrun_r, credit_err_r;
    logic [15:0]            frame_cnt_r;

    logic run_s, drain_s, idle_s, pop_s, push_s, room_s, cred_ok_s, issue_s;
    logic last_rd_s, final_pop_s, dec_s, inc_s;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    if (start)     state_nxt_s = RUN;   else state_nxt_s = IDLE;
            RUN:     if (last_rd_s) state_nxt_s = DRAIN; else state_nxt_s = RUN;
            DRAIN:   if (done_r)    state_nxt_s = IDLE;  else state_nxt_s = DRAIN;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State decode
    always_comb begin
        idle_s  = 1'b0;
        run_s   = 1'b0;
        drain_s = 1'b0;
        case (state_r)
            IDLE:    idle_s  = 1'b1;
            RUN:     run_s   = 1'b1;
            DRAIN:   drain_s = 1'b1;
            default: idle_s  = 1'b1;
        endcase
    end

    // A read may issue only if its data is guaranteed a buffer slot when it lands.
    assign pop_s       = out_valid & out_ready;
    assign push_s      = pend_r;
    assign room_s      = ({1'b0, occ_r} + {2'b00, pend_r}) < (3'd2 + {2'b00, pop_s});
    assign cred_ok_s   = (smp_r != {CW{1'b0}}) | (credits_r != {KW{1'b0}});
    assign issue_s     = run_s & room_s & cred_ok_s & ~rst;
    assign last_rd_s   = issue_s & (ch_r == CH_LAST) & (smp_r == SMP_LAST);
    assign final_pop_s = drain_s & pop_s & (occ_r == 2'd1) & ~pend_r;
    assign dec_s       = issue_s & (smp_r == {CW{1'b0}});
    assign inc_s       = fft_done & (credits_r != CRED_MAX);

    // Read sequencing, credits and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_r         <= {IW{1'b0}};
            smp_r        <= {CW{1'b0}};
            credits_r    <= CRED_MAX;
            pend_r       <= 1'b0;
            tag_r        <= {(IW+CW){1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            overrun_r    <= 1'b0;
            credit_err_r <= 1'b0;
            frame_cnt_r  <= 16'd0;
        end else begin
            if (idle_s && start) begin
                ch_r  <= {IW{1'b0}};
                smp_r <= {CW{1'b0}};
            end else if (issue_s) begin
                if (smp_r == SMP_LAST) begin
                    smp_r <= {CW{1'b0}};
                    ch_r  <= ch_r + 1'b1;
                end else begin
                    smp_r <= smp_r + 1'b1;
                end
            end else begin
                smp_r <= smp_r;
            end
            if (dec_s && !fft_done) begin
                credits_r <= credits_r - 1'b1;
            end else if (inc_s && !dec_s) begin
                credits_r <= credits_r + 1'b1;
            end else begin
                credits_r <= credits_r;
            end
            pend_r       <= issue_s;
            tag_r        <= {ch_r, smp_r};
            credit_err_r <= credit_err_r | (fft_done & (credits_r == CRED_MAX));
            overrun_r    <= overrun_r | (start & busy_r);
            done_r       <= final_pop_s;
            frame_cnt_r  <= frame_cnt_r + {15'd0, done_r};
            if (idle_s && start) begin
                busy_r <= 1'b1;
            end else if (done_r) begin
                busy_r <= 1'b0;
            end else begin
                busy_r <= busy_r;
            end
        end
    end

    // Two-entry output buffer; slot 0 is the stream head
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_r   <= 2'd0;
            data0_r <= {DATA_WIDTH{1'b0}};
            data1_r <= {DATA_WIDTH{1'b0}};
            tag0_r  <= {(IW+CW){1'b0}};
            tag1_r  <= {(IW+CW){1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (occ_r == 2'd0) begin
                        data0_r <= rd_data;
                        tag0_r  <= tag_r;
                    end else begin
                        data1_r <= rd_data;
                        tag1_r  <= tag_r;
                    end
                    occ_r <= occ_r + 2'd1;
                end
                2'b01: begin
                    data0_r <= data1_r;
                    tag0_r  <= tag1_r;
                    occ_r   <= occ_r - 2'd1;
                end
                2'b11: begin
                    if (occ_r == 2'd1) begin
                        data0_r <= rd_data;
                        tag0_r  <= tag_r;
                    end else begin
                        data0_r <= data1_r;
                        tag0_r  <= tag1_r;
                        data1_r <= rd_data;
                        tag1_r  <= tag_r;
                    end
                end
                default: occ_r <= occ_r;
            endcase
        end
    end

    assign rd_en      = issue_s;
    assign rd_addr    = {ch_r, smp_r};
    assign data_out   = data0_r;
    assign data_index = tag0_r[IW+CW-1:CW];
    assign data_count = tag0_r[CW-1:0];
    assign out_valid  = (occ_r != 2'd0);
    assign busy       = busy_r;
    assign done       = done_r;
    assign overrun    = overrun_r;
    assign credit_err = credit_err_r;
    assign frame_cnt  = frame_cnt_r;
endmodule

// File: tb/tb_second_fft_sched.sv
// Bench for second_fft_sched: random memory contents and backpressure, checked against
// the ideal beat order, a frame-credit window and an FFT completion emulator.
module tb_second_fft_sched;
    localparam int DW    = 64;
    localparam int NF    = 128;
    localparam int DEPTH = 32;
    localparam int DEC   = 2;
    localparam int MI    = 4;
    localparam int FL    = DEPTH / DEC;
    localparam int CW    = $clog2(DEPTH) - $clog2(DEC);
    localparam int IW    = $clog2(NF);
    localparam int AW    = IW + CW;
    localparam int BEATS = NF * FL;

    logic          clk = 1'b0;
    logic          rst, start, out_ready, fft_done;
    logic          busy, done, overrun, credit_err, rd_en, out_valid;
    logic [15:0]   frame_cnt;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data, data_out;
    logic [CW-1:0] data_count;
    logic [IW-1:0] data_index;

    second_fft_sched #(.DATA_WIDTH(DW), .N_FREQ(NF), .DEPTH(DEPTH), .ASSERT(DEC),
                       .MAX_INFLIGHT(MI)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .overrun(overrun), .credit_err(credit_err), .frame_cnt(frame_cnt),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .data_out(data_out),
        .data_count(data_count), .data_index(data_index), .out_valid(out_valid),
        .out_ready(out_ready), .fft_done(fft_done)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [BEATS];
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    int n_checks = 0, n_fail = 0;
    int cyc = 0, beats = 0, done_seen = 0, last_hs_cyc = -10;
    int dones_sent = 0, dones_base = 0;
    int due_q[$];
    bit auto_fft = 1'b1, ready_rand = 1'b0, prev_stall = 1'b0, sim_fired = 1'b0;
    logic [IW+CW+DW-1:0] prev_head;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: drive inputs at the falling edge, observe, model handshakes and FFT completions.
    task automatic cycle(input bit st, input int mode);
        bit fire;
        logic [IW-1:0] exp_idx;
        logic [CW-1:0] exp_cnt;
        @(negedge clk);
        cyc++;
        start     = st;
        out_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        fft_done  = 1'b0;
        #1;
        if (done) begin
            done_seen++;
            check("done_timing", cyc, last_hs_cyc + 1);
        end
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("hold", {out_valid, data_index, data_count, data_out}, {1'b1, prev_head});
            if (out_valid && out_ready) begin
                if (beats >= BEATS) begin
                    check("beat_overflow", beats, BEATS - 1);
                end else begin
                    exp_idx = IW'(beats / FL);
                    exp_cnt = CW'(beats % FL);
                    check("beat", {data_index, data_count, data_out}, {exp_idx, exp_cnt, mem[beats]});
                    check("credit_window", (beats / FL) < (MI + dones_sent - dones_base), 1);
                    if (auto_fft && (beats % FL) == FL - 1) due_q.push_back(cyc + 20);
                    if (beats == BEATS - 1) last_hs_cyc = cyc;
                end
                beats++;
            end
            prev_stall = out_valid && !out_ready;
            prev_head  = {data_index, data_count, data_out};
        end
        fire = (mode == 1) || (mode == 2 && rd_en && rd_addr[CW-1:0] == {CW{1'b0}});
        if (mode == 2 && fire) sim_fired = 1'b1;
        if (fire) begin
            fft_done = 1'b1;
            dones_sent++;
        end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
            void'(due_q.pop_front());
            fft_done = 1'b1;
            dones_sent++;
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        due_q.delete();
        beats = 0;
        repeat (n) cycle(1'b0, 0);
        rst = 1'b0;
        prev_stall = 1'b0;
    endtask

    task automatic begin_block();
        beats = 0;
        dones_base = dones_sent;
        cycle(1'b1, 0);
    endtask

    task automatic run_until_done(input int limit);
        int t = 0;
        int d0 = done_seen;
        while (done_seen == d0 && t < limit) begin
            cycle(1'b0, 0);
            t++;
        end
        check("block_done", done_seen - d0, 1);
        check("block_beats", beats, BEATS);
    endtask

    task automatic drain_fft();
        int t = 0;
        while (due_q.size() > 0 && t < 200) begin
            cycle(1'b0, 0);
            t++;
        end
        check("fft_drain", due_q.size(), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; out_ready = 1'b0; fft_done = 1'b0;
        for (int i = 0; i < BEATS; i++) mem[i] = {$urandom, $urandom};

        do_reset(3);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overrun", overrun, 0);
        check("rst_credit_err", credit_err, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_out_valid", out_valid, 0);

        // Basic block, full throughput
        begin_block();
        run_until_done(8000);
        repeat (2) cycle(1'b0, 0);
        check("basic_frame_cnt", frame_cnt, 1);
        check("basic_busy", busy, 0);
        drain_fft();

        // Random backpressure
        ready_rand = 1'b1;
        begin_block();
        run_until_done(12000);
        repeat (2) cycle(1'b0, 0);
        check("bp_frame_cnt", frame_cnt, 2);
        drain_fft();
        ready_rand = 1'b0;

        // Credit stall, single return, then coincident return and read
        auto_fft = 1'b0;
        begin_block();
        repeat (200) cycle(1'b0, 0);
        check("stall_beats", beats, MI * FL);
        check("stall_valid", out_valid, 0);
        check("stall_rd_en", rd_en, 0);
        cycle(1'b0, 1);
        repeat (60) cycle(1'b0, 0);
        check("one_credit_beats", beats, (MI + 1) * FL);
        check("one_credit_valid", out_valid, 0);
        cycle(1'b0, 1);
        sim_fired = 1'b0;
        cycle(1'b0, 2);
        check("sim_read_seen", sim_fired, 1);
        repeat (80) cycle(1'b0, 0);
        check("sim_credit_beats", beats, (MI + 3) * FL);
        auto_fft = 1'b1;
        repeat (MI) cycle(1'b0, 1);
        run_until_done(8000);
        repeat (2) cycle(1'b0, 0);
        check("stall_frame_cnt", frame_cnt, 3);
        drain_fft();

        // Spurious completion with all credits home
        repeat (3) cycle(1'b0, 0);
        check("cerr_before", credit_err, 0);
        cycle(1'b0, 1);
        cycle(1'b0, 0);
        check("cerr_set", credit_err, 1);
        auto_fft = 1'b0;
        begin_block();
        repeat (150) cycle(1'b0, 0);
        check("cerr_credits_kept", beats, MI * FL);
        check("cerr_busy", busy, 1);
        do_reset(1);
        check("rst2_busy", busy, 0);
        check("rst2_valid", out_valid, 0);
        check("rst2_credit_err", credit_err, 0);
        check("rst2_frame_cnt", frame_cnt, 0);

        // Overrun: start while busy is ignored
        auto_fft = 1'b1;
        ready_rand = 1'b1;
        begin_block();
        for (int t = 0; t < 1000 && beats < 100; t++) cycle(1'b0, 0);
        cycle(1'b1, 0);
        cycle(1'b0, 0);
        check("overrun_set", overrun, 1);
        run_until_done(12000);
        drain_fft();
        repeat (50) cycle(1'b0, 0);
        check("overrun_frame_cnt", frame_cnt, 1);
        check("overrun_no_second", beats, BEATS);
        check("overrun_busy", busy, 0);
        ready_rand = 1'b0;

        // Mid-block reset and restart
        begin_block();
        for (int t = 0; t < 2000 && beats < 500; t++) cycle(1'b0, 0);
        do_reset(1);
        check("mid_valid", out_valid, 0);
        check("mid_busy", busy, 0);
        check("mid_overrun", overrun, 0);
        check("mid_credit_err", credit_err, 0);
        check("mid_frame_cnt", frame_cnt, 0);
        begin_block();
        run_until_done(8000);
        repeat (2) cycle(1'b0, 0);
        check("mid_restart_frame_cnt", frame_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
